// File: rtl/bist_pkg.sv
// Shared constants for the convolutional-encoder BIST engine: mode encodings,
// default generator polynomials and the default PRBS tap/seed values.
package bist_pkg;

  typedef enum logic [1:0] {
    MODE_FREE  = 2'b00,
    MODE_SELF  = 2'b01,
    MODE_ALT   = 2'b10,
    MODE_ALT_B = 2'b11
  } mode_e;

  localparam logic [7:0] PRBS_TAPS_DEF = 8'h8E;
  localparam logic [7:0] PRBS_SEED_DEF = 8'h01;
  localparam logic [2:0] G0_DEF        = 3'b111;
  localparam logic [2:0] G1_DEF        = 3'b101;

endpackage

// File: rtl/bist_delay_line.sv
// Width x depth shift register that advances only on enabled cycles;
// used to delay-match the reference tag against the decoder latency.
module bist_delay_line
  import bist_pkg::*;
#(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/conv_enc_bist.sv
// PRBS source, rate-1/2 convolutional encoder, frame/sync generator and
// delay-matched scorer that grades the Viterbi decoder output on-chip.
module conv_enc_bist
  import bist_pkg::*;
#(
  parameter int unsigned       PRBS_W    = 8,
  parameter logic [PRBS_W-1:0] PRBS_TAPS = PRBS_W'(PRBS_TAPS_DEF),
  parameter logic [PRBS_W-1:0] PRBS_SEED = PRBS_W'(PRBS_SEED_DEF),
  parameter int unsigned       K         = 3,
  parameter logic [K-1:0]      G0        = K'(G0_DEF),
  parameter logic [K-1:0]      G1        = K'(G1_DEF),
  parameter int unsigned       FRAME_LEN = 100,
  parameter int unsigned       DELAY     = 36,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             clr_i,
  output logic             sync_o,
  output logic             self_test_o,
  output logic [1:0]       y_o,
  output logic             orig_bit_o,
  output logic             ref_bit_o,
  input  logic             dut_valid_i,
  input  logic             dut_bit_i,
  output logic             mismatch_o,
  output logic [CNT_W-1:0] st_bits_o,
  output logic [CNT_W-1:0] st_errs_o,
  output logic [CNT_W-1:0] fr_bits_o,
  output logic [CNT_W-1:0] fr_errs_o
);

  localparam int unsigned   CW       = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN);

  logic [CW-1:0]     cnt;
  logic [PRBS_W-1:0] lfsr;
  logic [K-2:0]      h;
  logic [K-1:0]      v;
  logic              st_next;
  logic              tag_mode, tag_sync;
  logic              score, err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  assign sync_o     = (cnt == CNT_LAST);
  assign orig_bit_o = lfsr[PRBS_W-1];
  assign v          = {orig_bit_o, h};
  assign y_o        = {^(v & G1), ^(v & G0)};

  // Mode only changes on the sync edge, so a frame is never split across modes.
  always_comb begin
    st_next = self_test_o;
    if (sync_o) begin
      case (mode_e'(mode_i))
        MODE_FREE: st_next = 1'b0;
        MODE_SELF: st_next = 1'b1;
        default:   st_next = ~self_test_o;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      lfsr        <= PRBS_SEED;
      h           <= '0;
      self_test_o <= 1'b0;
    end else if (en_i) begin
      cnt         <= sync_o ? '0 : cnt + CW'(1);
      lfsr        <= sync_o ? PRBS_SEED : {lfsr[PRBS_W-2:0], ^(lfsr & PRBS_TAPS)};
      h           <= sync_o ? '0 : {orig_bit_o, h[K-2:1]};
      self_test_o <= st_next;
    end
  end

  bist_delay_line #(
    .W     (3),
    .DEPTH (DELAY)
  ) u_tag_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_i),
    .d     ({orig_bit_o, self_test_o, sync_o}),
    .q     ({ref_bit_o, tag_mode, tag_sync})
  );

  assign score = en_i & dut_valid_i & ~tag_sync;
  assign err   = dut_bit_i ^ ref_bit_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_bits_o  <= '0;
      st_errs_o  <= '0;
      fr_bits_o  <= '0;
      fr_errs_o  <= '0;
      mismatch_o <= 1'b0;
    end else if (clr_i) begin
      st_bits_o  <= '0;
      st_errs_o  <= '0;
      fr_bits_o  <= '0;
      fr_errs_o  <= '0;
      mismatch_o <= 1'b0;
    end else if (score) begin
      mismatch_o <= err;
      if (tag_mode) begin
        st_bits_o <= sat_inc(st_bits_o, 1'b1);
        st_errs_o <= sat_inc(st_errs_o, err);
      end else begin
        fr_bits_o <= sat_inc(fr_bits_o, 1'b1);
        fr_errs_o <= sat_inc(fr_errs_o, err);
      end
    end
  end

endmodule

// File: tb/tb_conv_enc_bist.sv
// Self-checking bench for conv_enc_bist: a cycle model with a tag scoreboard
// queue, a reset vector table and directed multi-cycle corner cases.
module tb_conv_enc_bist;

  localparam int FRAME_LEN = 100;
  localparam int DELAY     = 36;

  logic clk = 1'b0;
  logic rst_n, en_i, clr_i, dut_valid_i, dut_bit_i;
  logic [1:0] mode_i;

  logic sync_o, self_test_o, orig_bit_o, ref_bit_o, mismatch_o;
  logic [1:0] y_o;
  logic [15:0] st_bits_o, st_errs_o, fr_bits_o, fr_errs_o;

  logic s_sync, s_st, s_orig, s_ref, s_mis;
  logic [1:0] s_y;
  logic [3:0] s_st_bits, s_st_errs, s_fr_bits, s_fr_errs;

  always #5 clk = ~clk;

  conv_enc_bist u_dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .mode_i(mode_i), .clr_i(clr_i),
    .sync_o(sync_o), .self_test_o(self_test_o), .y_o(y_o),
    .orig_bit_o(orig_bit_o), .ref_bit_o(ref_bit_o),
    .dut_valid_i(dut_valid_i), .dut_bit_i(dut_bit_i), .mismatch_o(mismatch_o),
    .st_bits_o(st_bits_o), .st_errs_o(st_errs_o),
    .fr_bits_o(fr_bits_o), .fr_errs_o(fr_errs_o)
  );

  conv_enc_bist #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .mode_i(mode_i), .clr_i(clr_i),
    .sync_o(s_sync), .self_test_o(s_st), .y_o(s_y),
    .orig_bit_o(s_orig), .ref_bit_o(s_ref),
    .dut_valid_i(dut_valid_i), .dut_bit_i(dut_bit_i), .mismatch_o(s_mis),
    .st_bits_o(s_st_bits), .st_errs_o(s_st_errs),
    .fr_bits_o(s_fr_bits), .fr_errs_o(s_fr_errs)
  );

  typedef struct {
    logic       orig;
    logic [1:0] y;
  } vec_t;
  vec_t tbl [9];

  int n_chk = 0;
  int n_fail = 0;

  int         m_cnt;
  logic [7:0] m_lfsr;
  logic [1:0] m_h;
  logic       m_st, m_mis;
  logic [2:0] tagq [$];
  int         m_st_bits, m_st_errs, m_fr_bits, m_fr_errs;

  int tick_no = 0;
  int tbl_idx = 9;
  logic sync_prev = 1'b0;
  int sync_ticks [$];
  logic st_after [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, tick_no);
    end
  endtask

  function automatic logic [3:0] sat4(input int c);
    logic [31:0] cv;
    cv = c;
    return (c > 15) ? 4'hF : cv[3:0];
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_lfsr = 8'h01; m_h = 2'b00; m_st = 1'b0; m_mis = 1'b0;
    m_st_bits = 0; m_st_errs = 0; m_fr_bits = 0; m_fr_errs = 0;
    tagq.delete();
    for (int i = 0; i < DELAY; i++) tagq.push_back(3'b000);
    sync_prev = 1'b0;
  endtask

  task automatic tick(input logic en, input logic valid, input logic inj,
                      input logic clr, input logic [1:0] mode);
    logic e_sync, e_orig, e_ref, t_mode, t_sync, err, fb;
    logic [1:0] e_y;
    logic [2:0] tag;
    logic [70:0] exp_v, act_v;
    logic [22:0] exp_s, act_s;
    e_sync = (m_cnt == FRAME_LEN);
    e_orig = m_lfsr[7];
    e_y    = {e_orig ^ m_h[0], e_orig ^ m_h[1] ^ m_h[0]};
    tag    = tagq[0];
    e_ref  = tag[2]; t_mode = tag[1]; t_sync = tag[0];
    en_i = en; dut_valid_i = valid; clr_i = clr; mode_i = mode;
    dut_bit_i = e_ref ^ inj;
    #3;
    exp_v = {e_sync, m_st, e_y, e_orig, e_ref, m_mis,
             16'(m_st_bits), 16'(m_st_errs), 16'(m_fr_bits), 16'(m_fr_errs)};
    act_v = {sync_o, self_test_o, y_o, orig_bit_o, ref_bit_o, mismatch_o,
             st_bits_o, st_errs_o, fr_bits_o, fr_errs_o};
    check("outputs", act_v, exp_v);
    exp_s = {e_sync, m_st, e_y, e_orig, e_ref, m_mis,
             sat4(m_st_bits), sat4(m_st_errs), sat4(m_fr_bits), sat4(m_fr_errs)};
    act_s = {s_sync, s_st, s_y, s_orig, s_ref, s_mis, s_st_bits, s_st_errs, s_fr_bits, s_fr_errs};
    check("sat_outputs", act_s, exp_s);
    if (en && tbl_idx < 9) begin
      check("reset_vector", {orig_bit_o, y_o}, {tbl[tbl_idx].orig, tbl[tbl_idx].y});
      tbl_idx++;
    end
    if (en) begin
      if (sync_prev) st_after.push_back(self_test_o);
      sync_prev = sync_o;
      if (sync_o) sync_ticks.push_back(tick_no);
    end
    err = dut_bit_i ^ e_ref;
    if (clr) begin
      m_st_bits = 0; m_st_errs = 0; m_fr_bits = 0; m_fr_errs = 0; m_mis = 1'b0;
    end else if (en && valid && !t_sync) begin
      m_mis = err;
      if (t_mode) begin m_st_bits++; m_st_errs += int'(err); end
      else        begin m_fr_bits++; m_fr_errs += int'(err); end
    end
    if (en) begin
      tagq.push_back({e_orig, m_st, e_sync});
      void'(tagq.pop_front());
      if (e_sync) begin
        m_cnt = 0; m_lfsr = 8'h01; m_h = 2'b00;
        if (mode == 2'b00) m_st = 1'b0;
        else if (mode == 2'b01) m_st = 1'b1;
        else m_st = ~m_st;
      end else begin
        m_cnt++;
        fb = m_lfsr[7] ^ m_lfsr[3] ^ m_lfsr[2] ^ m_lfsr[1];
        m_lfsr = {m_lfsr[6:0], fb};
        m_h = {e_orig, m_h[1]};
      end
    end
    tick_no++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 7; i++) tbl[i] = '{orig: 1'b0, y: 2'b00};
    tbl[7] = '{orig: 1'b1, y: 2'b11};
    tbl[8] = '{orig: 1'b0, y: 2'b01};

    rst_n = 1'b0; en_i = 1'b0; clr_i = 1'b0; dut_valid_i = 1'b0; dut_bit_i = 1'b0;
    mode_i = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {sync_o, self_test_o, y_o, ref_bit_o, mismatch_o, fr_bits_o, st_bits_o},
          {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'd0, 16'd0});
    rst_n = 1'b1;
    model_reset();
    tbl_idx = 0;

    // Alternating mode with loopback scoring for 500 cycles.
    for (int i = 0; i < 500; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
    check("sync_tick0", sync_ticks[0], 100);
    check("sync_tick1", sync_ticks[1], 201);
    check("sync_tick2", sync_ticks[2], 302);
    check("st_after_sync", {st_after[0], st_after[1], st_after[2]}, 3'b101);
    check("loop_st_bits", st_bits_o, 16'd200);
    check("loop_fr_bits", fr_bits_o, 16'd296);
    check("loop_errs", {st_errs_o, fr_errs_o}, 32'd0);

    // Clear, then a single inverted free-run bit.
    tick(1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
    check("clr_counts", {st_bits_o, fr_bits_o}, 32'd0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
    check("inj_fr_errs", fr_errs_o, 16'd1);
    check("inj_fr_bits", fr_bits_o, 16'd1);
    check("inj_mismatch", mismatch_o, 1'b1);
    check("inj_st_errs", st_errs_o, 16'd0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
    check("mismatch_clears", mismatch_o, 1'b0);

    // Freeze for 20 cycles mid-frame with junk on the decoder inputs.
    while (tick_no < 550) tick(1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
    repeat (20) tick(1'b0, 1'b1, 1'b1, 1'b0, 2'b10);
    while (tick_no < 640) tick(1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
    check("sync_gap_freeze", sync_ticks[$] - sync_ticks[$-1], 121);
    check("sync_after_freeze", sync_ticks[$], 625);

    // Reset mid-frame takes effect without a clock edge.
    rst_n = 1'b0;
    #2;
    check("midreset_state", {sync_o, self_test_o, y_o, orig_bit_o, mismatch_o, fr_errs_o, st_errs_o},
          {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'd0, 16'd0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tbl_idx = 0;

    // Saturation in free-run mode, then clear colliding with a scored error.
    repeat (20) tick(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
    check("sat_fr_errs", s_fr_errs, 4'hF);
    check("sat_fr_bits", s_fr_bits, 4'hF);
    check("wide_fr_errs", fr_errs_o, 16'd20);
    check("sat_mismatch", s_mis, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
    check("clr_wins_sat", {s_fr_errs, s_fr_bits, s_mis}, 9'd0);
    check("clr_wins_wide", {fr_errs_o, mismatch_o}, 17'd0);
    repeat (5) tick(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_enc_bist.md
# conv_enc_bist

Parametrised, synthesisable stimulus-and-check engine for the Viterbi decoder core. It contains:
- a PRBS source with configurable width and taps;
- a rate-1/2 convolutional encoder with configurable constraint length and generator polynomials;
- a frame/sync generator with selectable self-test / free-run / alternating mode;
- a delay-matched reference path with per-mode bit and error counters.

It sits beside the decoder core, driving its sync, self-test and encoded-symbol inputs, and scoring its decoded output on-chip instead of in a bench.

## Interface
Parameters:
- PRBS_W, 8, LFSR width (≥3)
- PRBS_TAPS, 8'h8E, feedback tap mask over the LFSR (bit i set = stage i tapped)
- PRBS_SEED, 8'h01, value loaded at reset and on every sync (nonzero)
- K, 3, encoder constraint length (3..9)
- G0, 3'b111, generator polynomial for y_o[0]; MSB weights the current bit, LSB the oldest bit
- G1, 3'b101, generator polynomial for y_o[1]
- FRAME_LEN, 100, enabled cycles per frame minus one (frame period = FRAME_LEN+1)
- DELAY, 36, decoder latency in enabled cycles, ≥1
- CNT_W, 16, counter width

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en_i  in  1  advance enable; when 0 all state holds
- mode_i  in  2  00 free-run, 01 self-test, 10 alternate per frame, 11 treated as 10
- clr_i  in  1  synchronous clear of all counters
- sync_o  out  1  frame start pulse to decoder
- self_test_o  out  1  current mode to decoder
- y_o  out  2  encoded symbol pair
- orig_bit_o  out  1  undelayed PRBS bit
- ref_bit_o  out  1  PRBS bit delayed DELAY enabled cycles
- dut_valid_i  in  1  decoder output valid
- dut_bit_i  in  1  decoder decoded bit
- mismatch_o  out  1  registered: last scored bit differed
- st_bits_o, st_errs_o  out  CNT_W  self-test scored bits / errors
- fr_bits_o, fr_errs_o  out  CNT_W  free-run scored bits / errors

## Operation
- Frame counter: cnt counts 0..FRAME_LEN on enabled cycles.
  - When cnt==FRAME_LEN: sync_o=1 for that cycle and cnt→0. Otherwise sync_o=0.
  - sync_o is combinational from cnt (registered source).
- Mode register:
  - mode_i 00/01 forces self_test_o to 0/1 at the next sync.
  - Alternate mode toggles self_test_o at each sync.
  - A mode_i change never takes effect mid-frame.
- PRBS:
  - orig_bit_o = lfsr[PRBS_W-1].
  - Enabled update: lfsr ← sync_o ? PRBS_SEED : {lfsr[PRBS_W-2:0], ^(lfsr & PRBS_TAPS)}.
- Encoder:
  - History h[K-2:0], newest bit in MSB. v = {orig_bit_o, h}.
  - y_o[0] = ^(v & G0); y_o[1] = ^(v & G1); both combinational.
  - Enabled update: h ← sync_o ? 0 : {orig_bit_o, h[K-2:1]}.
- Delay line: a DELAY-deep shift of the 3-bit tag {orig_bit_o, self_test_o, sync_o}, advancing on enabled cycles. Its output is {ref_bit_o, tag_mode, tag_sync}.
- Scoring happens on an enabled cycle with dut_valid_i=1 and tag_sync=0:
  - err = dut_bit_i ^ ref_bit_o.
  - The bits counter selected by tag_mode increments; its errs counter adds err.
  - mismatch_o ← err.
  - A tagged sync cycle is never scored.
- Counters saturate at all-ones.
- clr_i zeroes all four counters and mismatch_o. If clr_i and a score occur in the same cycle, the clear wins.

## Timing
- Reset values: cnt=0, lfsr=PRBS_SEED, h=0, self_test_o=0, delay line all zero, counters 0, mismatch_o=0. Hence sync_o=0 and y_o=00.
- Sync timing: the first sync_o is at the FRAME_LEN-th enabled cycle after reset (0-based); sync_o then repeats every FRAME_LEN+1 enabled cycles.
- self_test_o changes on the clock edge that ends the sync cycle.
- ref_bit_o equals orig_bit_o from exactly DELAY enabled cycles earlier.
- Counter and mismatch_o updates are visible one cycle after the scored edge.
- en_i=0 freezes everything, including outputs. dut_valid_i is ignored while en_i=0.
- Reset asserted mid-frame returns all state to reset values immediately. No partial frame is scored after release.

## Structure
- Shared package bist_pkg:
  - mode encodings (MODE_FREE, MODE_SELF, MODE_ALT);
  - default polynomials and the default PRBS tap/seed constants.
- One sub-module, bist_delay_line, a parametrised width × depth enabled shift register, reused for the tag path.
- The LFSR, encoder, frame counter and scorer live in the top level.

## Test plan
- Reset, then hold en_i=1 with defaults:
  - orig_bit_o for the first 8 cycles is 0,0,0,0,0,0,0,1;
  - y_o is 00 for cycles 0–6, 11 at cycle 7, 01 at cycle 8.
- Frame with mode_i=10: sync_o is high at cycles 100, 201, 302; self_test_o is 0→1→0→1 after each; the LFSR equals 8'h01 on the cycle after each sync.
- Loopback: drive dut_bit_i=ref_bit_o, dut_valid_i=1 for 500 cycles → errors stay 0 and bits total 500 minus the tag-sync cycles, split by mode.
- Inject an inverted dut_bit_i on one free-run scored cycle → fr_errs_o=1, mismatch_o=1 for one update; st_errs_o=0.
- en_i=0 for 20 cycles mid-frame → all outputs are frozen; the next sync is delayed by exactly 20 cycles.
- Counter saturation with CNT_W=4: after 20 errors fr_errs_o=15. clr_i asserted simultaneously with a scored error → counter reads 0.
